// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - parametrised immediate extender feeding a 2-entry skid buffer
module imm_ext_pipe #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 32,
  parameter int SHL   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  // Wide enough to hold the full shifted value, so lost bits can be inspected.
  localparam int WIDE_W = OUT_W + SHL;

  logic [WIDE_W-1:0] sext_wide;
  logic [WIDE_W-1:0] shifted;
  logic [OUT_W-1:0]  ext_data;
  logic              ext_ovf;

  always_comb begin
    sext_wide = {{(WIDE_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    shifted   = sext_wide << SHL;
    ext_data  = '0;
    ext_ovf   = 1'b0;
    case (in_mode)
      2'd0: ext_data = sext_wide[OUT_W-1:0];
      2'd1: ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'd2: ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: begin
        ext_data = shifted[OUT_W-1:0];
        // Shifted-out bits and result MSB must all agree for the value to fit.
        ext_ovf  = !((&shifted[WIDE_W-1:OUT_W-1]) || !(|shifted[WIDE_W-1:OUT_W-1]));
      end
    endcase
  end

  logic [OUT_W-1:0] mem_data [2];
  logic [TAG_W-1:0] mem_tag  [2];
  logic             mem_ovf  [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_tag[0]  <= '0;
      mem_tag[1]  <= '0;
      mem_ovf[0]  <= 1'b0;
      mem_ovf[1]  <= 1'b0;
    end else begin
      if (push) begin
        mem_data[tail] <= ext_data;
        mem_tag[tail]  <= in_tag;
        mem_ovf[tail]  <= ext_ovf;
        tail           <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_data = mem_data[head];
  assign out_tag  = mem_tag[head];
  assign out_ovf  = mem_ovf[head];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - scoreboard bench for imm_ext_pipe (default and 18-bit output instances)
module tb_imm_ext_pipe;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [16:0] a_in_imm;
  logic [1:0]  a_in_mode;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [16:0] b_in_imm;
  logic [1:0]  b_in_mode;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [17:0] b_out_data;

  int errors = 0;
  int checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  imm_ext_pipe dut_a (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm), .in_mode(a_in_mode),
    .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag), .out_ovf(a_out_ovf)
  );

  imm_ext_pipe #(.IN_W(17), .OUT_W(18), .SHL(2), .TAG_W(5)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
    .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .out_ovf(b_out_ovf)
  );

  // Arithmetic reference: signed integer value, then range check against OUT_W.
  function automatic exp_t model(input logic [16:0] imm, input logic [1:0] mode,
                                 input logic [4:0] tag, input int out_w);
    exp_t   e;
    longint s, v, lo, hi;
    s = imm[16] ? (longint'(imm) - (longint'(1) << 17)) : longint'(imm);
    e.tag = tag;
    e.ovf = 1'b0;
    case (mode)
      2'd0: v = s;
      2'd1: v = longint'(imm);
      2'd2: v = longint'(imm) << (out_w - 17);
      default: begin
        v  = s * 4;
        lo = -(longint'(1) << (out_w - 1));
        hi = (longint'(1) << (out_w - 1)) - 1;
        e.ovf = (v < lo) || (v > hi);
      end
    endcase
    e.data = 32'(v & ((longint'(1) << out_w) - 1));
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic [4:0] t, input logic o);
    exp_t e;
    e.data = d;
    e.tag  = t;
    e.ovf  = o;
    return e;
  endfunction

  always begin
    exp_t ea;
    @(negedge clock);
    #2;
    if (!reset && a_out_valid && a_out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_output: got data=%h tag=%0d, required no output", a_out_data, a_out_tag);
      end else begin
        ea = qa.pop_front();
        if ({a_out_data, a_out_tag, a_out_ovf} !== {ea.data, ea.tag, ea.ovf}) begin
          errors++;
          $display("FAIL a_output: got data=%h tag=%0d ovf=%b, required data=%h tag=%0d ovf=%b",
                   a_out_data, a_out_tag, a_out_ovf, ea.data, ea.tag, ea.ovf);
        end
      end
    end
  end

  always begin
    exp_t eb;
    @(negedge clock);
    #2;
    if (!reset && b_out_valid && b_out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_output: got data=%h tag=%0d, required no output", b_out_data, b_out_tag);
      end else begin
        eb = qb.pop_front();
        if ({b_out_data, b_out_tag, b_out_ovf} !== {eb.data[17:0], eb.tag, eb.ovf}) begin
          errors++;
          $display("FAIL b_output: got data=%h tag=%0d ovf=%b, required data=%h tag=%0d ovf=%b",
                   b_out_data, b_out_tag, b_out_ovf, eb.data[17:0], eb.tag, eb.ovf);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the push.
  task automatic send_a(input logic [16:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                        input exp_t e);
    int n = 0;
    a_in_valid = 1'b1; a_in_imm = imm; a_in_mode = mode; a_in_tag = tag;
    while (!a_in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!a_in_ready) begin
      checks++; errors++;
      $display("FAIL a_send_timeout: in_ready=%b, required 1 within 50 cycles", a_in_ready);
    end else begin
      qa.push_back(e);
    end
    @(negedge clock);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [16:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                        input exp_t e);
    int n = 0;
    b_in_valid = 1'b1; b_in_imm = imm; b_in_mode = mode; b_in_tag = tag;
    while (!b_in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!b_in_ready) begin
      checks++; errors++;
      $display("FAIL b_send_timeout: in_ready=%b, required 1 within 50 cycles", b_in_ready);
    end else begin
      qb.push_back(e);
    end
    @(negedge clock);
    b_in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 30) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d, required 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_imm = '0; a_in_mode = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_data, a_out_tag, a_out_ovf} !== {1'b0, 1'b1, 32'h0, 5'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state_a: got valid=%b ready=%b data=%h tag=%0d ovf=%b, required 0 1 0 0 0",
               a_out_valid, a_in_ready, a_out_data, a_out_tag, a_out_ovf);
    end
    checks++;
    if ({b_out_valid, b_in_ready, b_out_data} !== {1'b0, 1'b1, 18'h0}) begin
      errors++;
      $display("FAIL reset_state_b: got valid=%b ready=%b data=%h, required 0 1 0",
               b_out_valid, b_in_ready, b_out_data);
    end
  endtask

  task automatic test_sign;
    send_a(17'h10000, 2'd0, 5'd1, mk(32'hFFFF0000, 5'd1, 1'b0));
    checks++;
    if ({a_out_valid, a_out_data} !== {1'b1, 32'hFFFF0000}) begin
      errors++;
      $display("FAIL sign_latency: got valid=%b data=%h, required 1 ffff0000", a_out_valid, a_out_data);
    end
    send_a(17'h0FFFF, 2'd0, 5'd2, mk(32'h0000FFFF, 5'd2, 1'b0));
    drain();
  endtask

  task automatic test_modes;
    send_a(17'h1ABCD, 2'd1, 5'd3, mk(32'h0001ABCD, 5'd3, 1'b0));
    send_a(17'h00001, 2'd2, 5'd7, mk(32'h00008000, 5'd7, 1'b0));
    send_a(17'h1FFFF, 2'd3, 5'd9, mk(32'hFFFFFFFC, 5'd9, 1'b0));
    drain();
  endtask

  task automatic test_narrow;
    send_b(17'h08000, 2'd3, 5'd4, mk(32'h00020000, 5'd4, 1'b1));
    send_b(17'h00003, 2'd3, 5'd5, mk(32'h0000000C, 5'd5, 1'b0));
    send_b(17'h1FFFF, 2'd3, 5'd6, mk(32'h0003FFFC, 5'd6, 1'b0));
    send_b(17'h10000, 2'd3, 5'd8, mk(32'h00000000, 5'd8, 1'b1));
    drain();
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    a_out_ready = 1'b0;
    send_a(17'h00011, 2'd1, 5'd10, mk(32'h00000011, 5'd10, 1'b0));
    send_a(17'h10022, 2'd0, 5'd11, mk(32'hFFFF0022, 5'd11, 1'b0));
    held = a_out_data;
    a_in_valid = 1'b1; a_in_imm = 17'h00033; a_in_mode = 2'd2; a_in_tag = 5'd12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a_in_ready, a_out_valid, a_out_data} !== {1'b0, 1'b1, 32'h00000011}) begin
        errors++;
        $display("FAIL stall_%0d: got ready=%b valid=%b data=%h, required 0 1 00000011",
                 i, a_in_ready, a_out_valid, a_out_data);
      end
      @(negedge clock);
    end
    checks++;
    if (a_out_data !== held) begin
      errors++;
      $display("FAIL stall_stable: got data=%h, required %h", a_out_data, held);
    end
    a_out_ready = 1'b1;
    send_a(17'h00033, 2'd2, 5'd12, mk(32'h00198000, 5'd12, 1'b0));
    drain();
  endtask

  task automatic test_back_to_back;
    logic [16:0] imm;
    logic [1:0]  mode;
    a_out_ready = 1'b0;
    send_a(17'h00100, 2'd1, 5'd20, mk(32'h00000100, 5'd20, 1'b0));
    a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imm  = 17'($urandom);
      mode = 2'($urandom_range(0, 3));
      send_a(imm, mode, 5'(i), model(imm, mode, 5'(i), 32));
      checks++;
      if ({a_out_valid, a_in_ready} !== 2'b11) begin
        errors++;
        $display("FAIL count_one_%0d: got valid=%b ready=%b, required 1 1", i, a_out_valid, a_in_ready);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1'b0;
    send_a(17'h00055, 2'd1, 5'd21, mk(32'h00000055, 5'd21, 1'b0));
    send_a(17'h00066, 2'd1, 5'd22, mk(32'h00000066, 5'd22, 1'b0));
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL full_before_reset: got valid=%b ready=%b, required 1 0", a_out_valid, a_in_ready);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b, required 0 1", a_out_valid, a_in_ready);
    end
    qa.delete();
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_reset: got valid=%b ready=%b, required 0 1", a_out_valid, a_in_ready);
    end
    a_out_ready = 1'b1;
    send_a(17'h1F000, 2'd3, 5'd23, mk(32'hFFFFC000, 5'd23, 1'b0));
    drain();
  endtask

  initial begin
    test_reset();
    test_sign();
    test_modes();
    test_narrow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
